wb_rst_seq: RTL and testbench

WB_RST_SEQ -- requirements
Module: wb_rst_seq

---
 rtl/wb_rst_seq_pkg.sv | 36 +++
 rtl/rst_sync.sv | 22 ++
 rtl/wb_rst_seq.sv | 201 ++++++++++++++++++++
 tb/tb_wb_rst_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_rst_seq_pkg.sv
// Shared definitions for the Wishbone reset sequencer: FSM state codes,
// reset-cause codes, register word offsets and a byte-lane merge helper.
package wb_rst_seq_pkg;

  // FSM state encoding (also visible in STATUS[9:8])
  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Reason for the most recent reset sequence (STATUS[13:12])
  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_EXT  = 2'd1,
    CAUSE_SOFT = 2'd2,
    CAUSE_WDT  = 2'd3
  } cause_e;

  // Register word addresses (byte offset >> 2)
  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_DELAY  = 2'd2;
  localparam logic [1:0] ADR_WDOG   = 2'd3;

  // Replace the byte lanes of old_word selected by sel with those of new_word
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously with rst_n low,
// releases sync_n two clock edges after rst_n rises.
module rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic sync_n
);

  logic meta;

  // Shift a constant 1 through two flops; both clear immediately on rst_n low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync_n <= 1'b0;
    end else begin
      meta   <= 1'b1;
      sync_n <= meta;
    end
  end

endmodule

// File: rtl/wb_rst_seq.sv
// Wishbone-controlled reset sequencer. Holds all rst_o high, then releases
// channel 0, 1, ... one at a time with DELAY+1 cycles per stage.
// Optional watchdog retrigger is compiled in with WB_RST_SEQ_WDT_EN.
//
// Bus handshake: a request is taken on any cycle where cyc & stb are high
// and ack is low; ack is then high for exactly one cycle (with registered
// read data), so at most one transfer completes every two cycles.
module wb_rst_seq
  import wb_rst_seq_pkg::*;
#(
  parameter int NUM_RST   = 3,
  parameter int CNT_W     = 8,
  parameter int STAGE_DLY = 16
) (
  input  logic               wb_clk_i,
  input  logic               reset_n,
  input  logic               ext_rst_i,
  input  logic [1:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic [NUM_RST-1:0] rst_o,
  output logic               done_o
);

  localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RST - 1);

  logic               sync_n;
  logic [1:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_RST-1:0] rst_fsm;
  logic [NUM_RST-1:0] hold;
  logic [CNT_W-1:0]   delay;
  cause_e             cause;
  logic               wb_req, wr_en, rd_en;
  logic               soft_trig, wdt_trig, trigger;
  logic [31:0]        delay_merged;
  logic [31:0]        rd_data;

  rst_sync u_rst_sync (
    .clk    (wb_clk_i),
    .rst_n  (reset_n),
    .sync_n (sync_n)
  );

  assign wb_req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en     = wb_req & wb_we_i;
  assign rd_en     = wb_req & ~wb_we_i;
  assign soft_trig = wr_en && (wb_adr_i == ADR_CTRL) && wb_sel_i[0] && wb_dat_i[0];
  assign trigger   = ext_rst_i | soft_trig | wdt_trig;

  assign delay_merged = byte_merge(32'(delay), wb_dat_i, wb_sel_i);

  // Sequencer FSM; a trigger (or a not-yet-synchronised reset) restarts it
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_ASSERT;
      idx     <= '0;
      cnt     <= '0;
      rst_fsm <= '1;
    end else if (!sync_n || trigger) begin
      state   <= ST_ASSERT;
      idx     <= '0;
      cnt     <= delay;
      rst_fsm <= '1;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == '0) begin
            state   <= ST_RELEASE;
            idx     <= '0;
            cnt     <= delay;
            rst_fsm <= rst_fsm << 1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx     <= idx + IDX_W'(1);
            cnt     <= delay;
            rst_fsm <= rst_fsm << 1;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: state <= ST_ASSERT;
      endcase
    end
  end

  // Record why the latest sequence started; external reset has priority
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cause <= CAUSE_POR;
    end else if (ext_rst_i) begin
      cause <= CAUSE_EXT;
    end else if (soft_trig) begin
      cause <= CAUSE_SOFT;
    end else if (wdt_trig) begin
      cause <= CAUSE_WDT;
    end
  end

  // HOLD mask and DELAY registers; only reset_n clears them
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      hold  <= '0;
      delay <= CNT_W'(STAGE_DLY);
    end else if (wr_en) begin
      if (wb_adr_i == ADR_CTRL && wb_sel_i[1]) hold <= wb_dat_i[8 +: NUM_RST];
      if (wb_adr_i == ADR_DELAY) delay <= delay_merged[CNT_W-1:0];
    end
  end

`ifdef WB_RST_SEQ_WDT_EN
  logic [CNT_W-1:0] wdog_reload;
  logic             wdog_en;
  logic [CNT_W-1:0] wdog_cnt;
  logic [31:0]      wdog_word;
  logic [31:0]      wdog_merged;

  always_comb begin
    wdog_word              = '0;
    wdog_word[CNT_W-1:0]   = wdog_reload;
    wdog_word[31]          = wdog_en;
  end

  assign wdog_merged = byte_merge(wdog_word, wb_dat_i, wb_sel_i);
  assign wdt_trig    = wdog_en && (state == ST_DONE) && (wdog_cnt == '0);

  // Watchdog: reload on any WDOG write, count down only while DONE
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wdog_reload <= '0;
      wdog_en     <= 1'b0;
      wdog_cnt    <= '0;
    end else if (wr_en && wb_adr_i == ADR_WDOG) begin
      wdog_reload <= wdog_merged[CNT_W-1:0];
      wdog_en     <= wdog_merged[31];
      wdog_cnt    <= wdog_merged[CNT_W-1:0];
    end else if (wdog_en && state == ST_DONE) begin
      if (wdog_cnt == '0) wdog_en <= 1'b0;
      else                wdog_cnt <= wdog_cnt - CNT_W'(1);
    end
  end
`else
  assign wdt_trig = 1'b0;
`endif

  // Register read mux; unused bits are zero
  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      ADR_CTRL: rd_data[8 +: NUM_RST] = hold;
      ADR_STATUS: begin
        rd_data[NUM_RST-1:0] = rst_o;
        rd_data[9:8]         = state;
        rd_data[13:12]       = cause;
        rd_data[16]          = done_o;
      end
      ADR_DELAY: rd_data[CNT_W-1:0] = delay;
      ADR_WDOG: begin
`ifdef WB_RST_SEQ_WDT_EN
        rd_data[CNT_W-1:0] = wdog_reload;
        rd_data[31]        = wdog_en;
`endif
      end
      default: rd_data = '0;
    endcase
  end

  // One-cycle ack with registered read data
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= wb_req;
      if (wb_req) wb_dat_o <= wb_we_i ? 32'h0 : rd_data;
    end
  end

  assign rst_o  = rst_fsm | hold;
  assign done_o = (state == ST_DONE);

  logic unused_bits;
  assign unused_bits = ^{wb_dat_i, wb_sel_i, delay_merged};

endmodule

// File: tb/tb_wb_rst_seq.sv
// Directed testbench for wb_rst_seq (default parameters). The watchdog
// section follows WB_RST_SEQ_WDT_EN the same way the design does.
module tb_wb_rst_seq;
  import wb_rst_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ext_rst_i = 1'b0;
  logic [1:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [2:0]  rst_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] q;

  wb_rst_seq dut (
    .wb_clk_i (clk),
    .reset_n  (reset_n),
    .ext_rst_i(ext_rst_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .rst_o    (rst_o),
    .done_o   (done_o)
  );

  // Clock: posedge at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #400000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n active edges, then settle 1ns past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdat);
    int n;
    wb_adr_i = a; wb_we_i = w; wb_dat_i = d; wb_sel_i = s;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!wb_ack_o && n < 8);
    check("wb_ack_seen", {31'b0, wb_ack_o}, 32'h1);
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(a, 1'b1, d, s, dummy);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] rdat);
    wb_xfer(a, 1'b0, 32'h0, 4'hF, rdat);
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int n = 0;
    while (!done_o && n < max_cyc) begin
      step(1);
      n++;
    end
    check(tag, {31'b0, done_o}, 32'h1);
  endtask

  task automatic wait_rst(input logic [2:0] exp, input int max_cyc, input string tag);
    int n = 0;
    while (rst_o !== exp && n < max_cyc) begin
      step(1);
      n++;
    end
    check(tag, {29'b0, rst_o}, {29'b0, exp});
  endtask

  initial begin
    // ---------------- Power-on reset ----------------
    step(3);
    check("por_rst_o", {29'b0, rst_o}, 32'h7);
    check("por_done", {31'b0, done_o}, 32'h0);
    check("por_ack", {31'b0, wb_ack_o}, 32'h0);
    check("por_dat", wb_dat_o, 32'h0);
    reset_n = 1'b1;
    step(18);
    check("por_hold_111", {29'b0, rst_o}, 32'h7);
    step(1);
    check("por_rel0", {29'b0, rst_o}, 32'h6);
    step(16);
    check("por_still_110", {29'b0, rst_o}, 32'h6);
    step(1);
    check("por_rel1", {29'b0, rst_o}, 32'h4);
    step(17);
    check("por_rel2", {29'b0, rst_o}, 32'h0);
    step(16);
    check("por_not_done", {31'b0, done_o}, 32'h0);
    step(1);
    check("por_done_set", {31'b0, done_o}, 32'h1);
    wb_read(ADR_STATUS, q);
    check("por_status", q, 32'h0001_0200);

    // ---------------- Ack pattern with cyc/stb held ----------------
    step(1);
    wb_adr_i = ADR_STATUS; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    step(1);
    check("ack_c1", {31'b0, wb_ack_o}, 32'h1);
    step(1);
    check("ack_c2", {31'b0, wb_ack_o}, 32'h0);
    step(1);
    check("ack_c3", {31'b0, wb_ack_o}, 32'h1);
    step(1);
    check("ack_c4", {31'b0, wb_ack_o}, 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

    // ---------------- Soft trigger from DONE ----------------
    wb_write(ADR_CTRL, 32'h1, 4'h1);
    check("soft_rst_o", {29'b0, rst_o}, 32'h7);
    check("soft_done_clr", {31'b0, done_o}, 32'h0);
    wb_read(ADR_STATUS, q);
    check("soft_status", q, 32'h0000_2007);
    wait_done(200, "soft_done");
    check("soft_end_rst", {29'b0, rst_o}, 32'h0);

    // ---------------- DELAY=0, one-cycle ext pulse ----------------
    wb_write(ADR_DELAY, 32'h0, 4'h1);
    ext_rst_i = 1'b1;
    step(1);
    ext_rst_i = 1'b0;
    check("ext_111", {29'b0, rst_o}, 32'h7);
    step(1);
    check("ext_110", {29'b0, rst_o}, 32'h6);
    step(1);
    check("ext_100", {29'b0, rst_o}, 32'h4);
    step(1);
    check("ext_000", {29'b0, rst_o}, 32'h0);
    check("ext_not_done", {31'b0, done_o}, 32'h0);
    step(1);
    check("ext_done", {31'b0, done_o}, 32'h1);
    wb_read(ADR_STATUS, q);
    check("ext_status", q, 32'h0001_1200);

    // ---------------- ext held keeps ASSERT ----------------
    ext_rst_i = 1'b1;
    step(5);
    check("ext_held_rst", {29'b0, rst_o}, 32'h7);
    check("ext_held_done", {31'b0, done_o}, 32'h0);
    ext_rst_i = 1'b0;
    step(1);
    check("ext_held_rel", {29'b0, rst_o}, 32'h6);
    wait_done(20, "ext_held_done_end");

    // ---------------- Simultaneous ext and SOFT ----------------
    ext_rst_i = 1'b1;
    wb_write(ADR_CTRL, 32'h1, 4'h1);
    ext_rst_i = 1'b0;
    wb_read(ADR_STATUS, q);
    check("both_cause", {30'b0, q[13:12]}, 32'h1);
    wait_done(20, "both_done");

    // ---------------- Byte enables on DELAY ----------------
    wb_write(ADR_DELAY, 32'h0000_00FF, 4'h2);
    wb_read(ADR_DELAY, q);
    check("dly_sel_masked", q, 32'h0);
    wb_write(ADR_DELAY, 32'h1234_5603, 4'h1);
    wb_read(ADR_DELAY, q);
    check("dly_sel_byte0", q, 32'h3);

    // ---------------- HOLD on channel 1 ----------------
    wb_write(ADR_CTRL, 32'h0000_0200, 4'h2);
    check("hold_forced", {29'b0, rst_o}, 32'h2);
    check("hold_done_kept", {31'b0, done_o}, 32'h1);
    wb_read(ADR_CTRL, q);
    check("hold_ctrl_rd", q, 32'h0000_0200);
    wb_write(ADR_CTRL, 32'h0000_0201, 4'h3);
    check("hold_soft_111", {29'b0, rst_o}, 32'h7);
    wait_done(100, "hold_done");
    check("hold_end_010", {29'b0, rst_o}, 32'h2);
    wb_write(ADR_CTRL, 32'h0, 4'h2);
    check("hold_clear_000", {29'b0, rst_o}, 32'h0);
    wb_read(ADR_CTRL, q);
    check("ctrl_soft_reads0", q, 32'h0);

    // ---------------- reset_n low mid-RELEASE ----------------
    wb_write(ADR_DELAY, 32'h5, 4'h1);
    wb_write(ADR_CTRL, 32'h1, 4'h1);
    wait_rst(3'b100, 100, "mid_reach_100");
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_async_111", {29'b0, rst_o}, 32'h7);
    check("mid_async_done", {31'b0, done_o}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wb_read(ADR_DELAY, q);
    check("mid_delay_por", q, 32'h10);
    wb_read(ADR_CTRL, q);
    check("mid_hold_por", q, 32'h0);
    wb_read(ADR_STATUS, q);
    check("mid_status_por", q, 32'h0000_0007);
    wb_read(ADR_WDOG, q);
    check("wdog_por", q, 32'h0);

    // ---------------- Watchdog ----------------
`ifdef WB_RST_SEQ_WDT_EN
    wait_done(200, "wdt_pre_done");
    wb_write(ADR_WDOG, 32'h8000_0004, 4'hF);
    step(4);
    check("wdt_not_yet", {29'b0, rst_o}, 32'h0);
    check("wdt_done_yet", {31'b0, done_o}, 32'h1);
    step(1);
    check("wdt_fire", {29'b0, rst_o}, 32'h7);
    wb_read(ADR_STATUS, q);
    check("wdt_cause", {30'b0, q[13:12]}, 32'h3);
    wb_read(ADR_WDOG, q);
    check("wdt_en_clear", q, 32'h0000_0004);
`else
    wb_write(ADR_WDOG, 32'hFFFF_FFFF, 4'hF);
    wb_read(ADR_WDOG, q);
    check("wdog_absent_rd", q, 32'h0);
    wait_done(200, "wdog_absent_done");
    step(20);
    check("wdog_absent_no_fire", {31'b0, done_o}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
